// File: rtl/debug_cmd_if.sv
// Byte-stream handshake bundle between the host debug transport (master)
// and debug_cmd_engine (slave): a command stream in, a framed response stream out.
interface debug_cmd_if;
  logic [7:0] cmd_data;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] resp_data;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_last;

  modport master (
    output cmd_data, cmd_valid, resp_ready,
    input  cmd_ready, resp_data, resp_valid, resp_last
  );

  modport slave (
    input  cmd_data, cmd_valid, resp_ready,
    output cmd_ready, resp_data, resp_valid, resp_last
  );
endinterface

// File: rtl/debug_cmd_engine.sv
// Framed debug command engine: parses opcode+args, snapshots status words, drives control
// registers and pulses, streams a response. Define DEBUG_CMD_CHECKSUM_EN for a trailing XOR byte.
module debug_cmd_engine #(
  parameter int          NUM_STATUS     = 8,
  parameter int          STATUS_BYTES   = 4,
  parameter int          NUM_CTRL       = 8,
  parameter int          NUM_PULSE      = 8,
  parameter int          TIMEOUT_CYCLES = 1024,
  parameter logic [23:0] VERSION        = 24'h020000
) (
  input  logic                                clk,
  input  logic                                rst_n,
  debug_cmd_if.slave                          bus,
  input  logic [NUM_STATUS*STATUS_BYTES*8-1:0] status_in,
  output logic [NUM_CTRL*8-1:0]               ctrl_out,
  output logic [NUM_PULSE-1:0]                pulse_out,
  output logic [7:0]                          timeout_count,
  output logic                                busy
);

  localparam int SW       = STATUS_BYTES * 8;
  localparam int BODY_MAX = 1 + ((STATUS_BYTES > 3) ? STATUS_BYTES : 3);
`ifdef DEBUG_CMD_CHECKSUM_EN
  localparam int CSUM_LEN = 1;
`else
  localparam int CSUM_LEN = 0;
`endif
  localparam int BUF_LEN  = BODY_MAX + CSUM_LEN;
  localparam int LEN_W    = $clog2(BUF_LEN + 1);
  localparam int TO_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_RD_STATUS = 8'h01;
  localparam logic [7:0] OP_WR_CTRL   = 8'h02;
  localparam logic [7:0] OP_RD_CTRL   = 8'h03;
  localparam logic [7:0] OP_PULSE     = 8'h04;
  localparam logic [7:0] OP_VERSION   = 8'hF0;
  localparam logic [7:0] RSP_UNKNOWN  = 8'hFF;
  localparam logic [7:0] RSP_RANGE    = 8'hFE;
  localparam logic [7:0] RSP_TIMEOUT  = 8'hFD;

  typedef enum logic [1:0] {IDLE, ARG, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              run_q;
  logic [7:0]        op_q, arg0_q, arg1_q;
  logic              arg_cnt_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic              abort_q;
  logic [7:0]        tmo_q;
  logic [7:0]        ctrl_q [NUM_CTRL];
  logic [7:0]        resp_buf_q [BUF_LEN];
  logic [LEN_W-1:0]  resp_len_q, resp_idx_q;

  logic [SW-1:0]     status_words [NUM_STATUS];
  logic [7:0]        exec_buf [BUF_LEN];
  logic [LEN_W-1:0]  exec_len;
  logic              ctrl_we;
  logic [SW-1:0]     sel_word;
  logic [7:0]        sel_ctrl;
  logic [7:0]        resp_byte;
  logic              cmd_fire, resp_fire, last_arg, to_expired, last_byte;

  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_RD_STATUS, OP_RD_CTRL, OP_PULSE: arg_count = 2'd1;
      OP_WR_CTRL:                         arg_count = 2'd2;
      default:                            arg_count = 2'd0;
    endcase
  endfunction

  for (genvar g = 0; g < NUM_STATUS; g++) begin : g_status
    assign status_words[g] = status_in[g*SW +: SW];
  end

  assign bus.cmd_ready  = run_q && (state_q == IDLE || state_q == ARG);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_data  = resp_byte;
  assign bus.resp_last  = (state_q == RESP) && last_byte;
  assign cmd_fire       = bus.cmd_valid && bus.cmd_ready;
  assign resp_fire      = bus.resp_valid && bus.resp_ready;
  assign last_byte      = (resp_idx_q == resp_len_q - LEN_W'(1));
  assign last_arg       = (arg_count(op_q) == (arg_cnt_q ? 2'd2 : 2'd1));
  assign to_expired     = (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign timeout_count  = tmo_q;
  assign busy           = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every signal assigned in an always_comb gets a default at the top so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_fire) state_d = (arg_count(bus.cmd_data) == 2'd0) ? EXEC : ARG;
      ARG: begin
        if (cmd_fire) begin
          if (last_arg) state_d = EXEC;
        end else if (to_expired) begin
          state_d = EXEC;
        end
      end
      EXEC:    state_d = RESP;
      RESP:    if (resp_fire && last_byte) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Response assembly; the status word is sampled here, in EXEC only, so the reply is atomic.
  always_comb begin
    exec_buf = '{default: 8'h00};
    exec_len = '0;
    ctrl_we  = 1'b0;
    sel_word = '0;
    sel_ctrl = '0;
    for (int i = 0; i < NUM_STATUS; i++)
      if (arg0_q == 8'(i)) sel_word = status_words[i];
    for (int i = 0; i < NUM_CTRL; i++)
      if (arg0_q == 8'(i)) sel_ctrl = ctrl_q[i];
    exec_buf[0] = op_q;
    if (abort_q) begin
      exec_buf[0] = RSP_TIMEOUT;
      exec_buf[1] = op_q;
      exec_len    = LEN_W'(2);
    end else begin
      case (op_q)
        OP_NOP: exec_len = LEN_W'(1);
        OP_RD_STATUS: begin
          if (arg0_q < 8'(NUM_STATUS)) begin
            for (int k = 0; k < STATUS_BYTES; k++) exec_buf[1+k] = sel_word[k*8 +: 8];
            exec_len = LEN_W'(1 + STATUS_BYTES);
          end else begin
            exec_buf[0] = RSP_RANGE;
            exec_buf[1] = arg0_q;
            exec_len    = LEN_W'(2);
          end
        end
        OP_WR_CTRL: begin
          if (arg0_q < 8'(NUM_CTRL)) begin
            exec_buf[1] = arg0_q;
            exec_buf[2] = arg1_q;
            exec_len    = LEN_W'(3);
            ctrl_we     = 1'b1;
          end else begin
            exec_buf[0] = RSP_RANGE;
            exec_buf[1] = arg0_q;
            exec_len    = LEN_W'(2);
          end
        end
        OP_RD_CTRL: begin
          exec_buf[1] = (arg0_q < 8'(NUM_CTRL)) ? sel_ctrl : arg0_q;
          if (arg0_q >= 8'(NUM_CTRL)) exec_buf[0] = RSP_RANGE;
          exec_len = LEN_W'(2);
        end
        OP_PULSE: begin
          if (arg0_q >= 8'(NUM_PULSE)) exec_buf[0] = RSP_RANGE;
          exec_buf[1] = arg0_q;
          exec_len    = LEN_W'(2);
        end
        OP_VERSION: begin
          exec_buf[1] = VERSION[23:16];
          exec_buf[2] = VERSION[15:8];
          exec_buf[3] = VERSION[7:0];
          exec_len    = LEN_W'(4);
        end
        default: begin
          exec_buf[0] = RSP_UNKNOWN;
          exec_buf[1] = op_q;
          exec_len    = LEN_W'(2);
        end
      endcase
    end
`ifdef DEBUG_CMD_CHECKSUM_EN
    begin : csum_blk
      logic [7:0] csum;
      csum = 8'h00;
      // Bytes past exec_len are zero, so folding the whole body leaves the XOR unchanged.
      for (int i = 0; i < BODY_MAX; i++) csum = csum ^ exec_buf[i];
      for (int i = 0; i < BUF_LEN; i++)
        if (LEN_W'(i) == exec_len) exec_buf[i] = csum;
      exec_len = exec_len + LEN_W'(1);
    end
`endif
  end

  // NOTE: sequential state is written with non-blocking assignments so every register
  // samples the pre-edge values and the evaluation order of blocks cannot matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q      <= 1'b0;
      op_q       <= '0;
      arg0_q     <= '0;
      arg1_q     <= '0;
      arg_cnt_q  <= 1'b0;
      to_cnt_q   <= '0;
      abort_q    <= 1'b0;
      tmo_q      <= '0;
      resp_len_q <= '0;
      resp_idx_q <= '0;
      ctrl_q     <= '{default: 8'h00};
    end else begin
      run_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            op_q      <= bus.cmd_data;
            arg_cnt_q <= 1'b0;
            to_cnt_q  <= '0;
            abort_q   <= 1'b0;
          end
        end
        ARG: begin
          if (cmd_fire) begin
            if (!arg_cnt_q) arg0_q <= bus.cmd_data;
            else            arg1_q <= bus.cmd_data;
            arg_cnt_q <= 1'b1;
            to_cnt_q  <= '0;
          end else if (to_expired) begin
            abort_q <= 1'b1;
            if (tmo_q != 8'hFF) tmo_q <= tmo_q + 8'd1;
          end else begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
          end
        end
        EXEC: begin
          resp_len_q <= exec_len;
          resp_idx_q <= '0;
          if (ctrl_we)
            for (int i = 0; i < NUM_CTRL; i++)
              if (arg0_q == 8'(i)) ctrl_q[i] <= arg1_q;
        end
        RESP: if (resp_fire) resp_idx_q <= resp_idx_q + LEN_W'(1);
        default: ;
      endcase
    end
  end

  // NOTE: the response buffer is plain storage with no reset; it is always fully
  // rewritten in EXEC before RESP reads it, unlike ctrl_q which drives outputs.
  always_ff @(posedge clk) begin
    if (state_q == EXEC) resp_buf_q <= exec_buf;
  end

  always_comb begin
    resp_byte = 8'h00;
    for (int i = 0; i < BUF_LEN; i++)
      if (resp_idx_q == LEN_W'(i)) resp_byte = resp_buf_q[i];
  end

  always_comb begin
    pulse_out = '0;
    if (state_q == EXEC && !abort_q && op_q == OP_PULSE)
      for (int i = 0; i < NUM_PULSE; i++)
        if (arg0_q == 8'(i)) pulse_out[i] = 1'b1;
  end

  always_comb begin
    ctrl_out = '0;
    for (int i = 0; i < NUM_CTRL; i++) ctrl_out[i*8 +: 8] = ctrl_q[i];
  end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Self-checking bench for debug_cmd_engine: a queue-based response model built from the opcode
// table, one per-cycle compare process, and literal expectations for the key frames.
module tb_debug_cmd_engine;
  localparam int          NS  = 8;
  localparam int          SB  = 4;
  localparam int          NC  = 8;
  localparam int          NP  = 8;
  localparam int          TO  = 40;
  localparam logic [23:0] VER = 24'h020000;
`ifdef DEBUG_CMD_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif

  typedef struct { logic [7:0] data; logic is_last; } exp_byte_t;
  typedef struct { logic [NC*8-1:0] ctrl; logic [7:0] tmo; } img_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_cmd_if bus();
  logic [NS*SB*8-1:0] status_in;
  logic [NC*8-1:0]    ctrl_out;
  logic [NP-1:0]      pulse_out;
  logic [7:0]         timeout_count;
  logic               busy;

  debug_cmd_engine #(
    .NUM_STATUS(NS), .STATUS_BYTES(SB), .NUM_CTRL(NC), .NUM_PULSE(NP),
    .TIMEOUT_CYCLES(TO), .VERSION(VER)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .status_in(status_in),
    .ctrl_out(ctrl_out), .pulse_out(pulse_out),
    .timeout_count(timeout_count), .busy(busy)
  );

  logic [SB*8-1:0] status_m [NS];
  always_comb
    for (int i = 0; i < NS; i++) status_in[i*SB*8 +: SB*8] = status_m[i];

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference model state
  exp_byte_t  exp_q [$];
  img_t       img_q [$];
  logic [7:0] ctrl_m [NC];
  logic [7:0] tmo_m;

  function automatic int argc(input logic [7:0] op);
    case (op)
      8'h01, 8'h03, 8'h04: return 1;
      8'h02:               return 2;
      default:             return 0;
    endcase
  endfunction

  task automatic model_push(input logic [7:0] op, input logic [7:0] idx,
                            input logic [7:0] dat, input int n);
    logic [7:0] r [$];
    logic [7:0] x;
    exp_byte_t  e;
    img_t       im;
    if (n < 1 + argc(op)) begin
      r.push_back(8'hFD); r.push_back(op);
      if (tmo_m != 8'hFF) tmo_m++;
    end else begin
      case (op)
        8'h00: r.push_back(8'h00);
        8'h01: if (idx < NS) begin
                 r.push_back(8'h01);
                 for (int k = 0; k < SB; k++) r.push_back(status_m[int'(idx)][k*8 +: 8]);
               end else begin r.push_back(8'hFE); r.push_back(idx); end
        8'h02: if (idx < NC) begin
                 ctrl_m[int'(idx)] = dat;
                 r.push_back(8'h02); r.push_back(idx); r.push_back(dat);
               end else begin r.push_back(8'hFE); r.push_back(idx); end
        8'h03: if (idx < NC) begin r.push_back(8'h03); r.push_back(ctrl_m[int'(idx)]); end
               else begin r.push_back(8'hFE); r.push_back(idx); end
        8'h04: begin r.push_back(idx < NP ? 8'h04 : 8'hFE); r.push_back(idx); end
        8'hF0: begin
                 r.push_back(8'hF0); r.push_back(VER[23:16]);
                 r.push_back(VER[15:8]); r.push_back(VER[7:0]);
               end
        default: begin r.push_back(8'hFF); r.push_back(op); end
      endcase
    end
`ifdef DEBUG_CMD_CHECKSUM_EN
    x = 8'h00;
    foreach (r[i]) x = x ^ r[i];
    r.push_back(x);
`endif
    foreach (r[i]) begin
      e.data = r[i];
      e.is_last = (i == r.size() - 1);
      exp_q.push_back(e);
    end
    for (int i = 0; i < NC; i++) im.ctrl[i*8 +: 8] = ctrl_m[i];
    im.tmo = tmo_m;
    img_q.push_back(im);
  endtask

  // Compare process: every valid cycle must show the head of the expected stream.
  logic       in_resp = 1'b0;
  int         first_valid_cyc = 0;
  logic [7:0] cur [16];
  int         cur_len = 0;
  logic [7:0] last_resp [16];
  int         last_len = 0;
  int         pulse_hits = 0;
  logic [NP-1:0] pulse_last = '0;

  always @(negedge clk) begin
    if (pulse_out != '0) begin pulse_hits++; pulse_last = pulse_out; end
    if (!rst_n) begin
      in_resp = 1'b0;
      cur_len = 0;
    end else if (bus.resp_valid) begin
      if (!in_resp) begin in_resp = 1'b1; first_valid_cyc = cyc; end
      if (exp_q.size() == 0) begin
        check("unexpected_resp_byte", bus.resp_data, 64'hFFFF);
      end else begin
        check("resp_data", bus.resp_data, exp_q[0].data);
        check("resp_last", bus.resp_last, exp_q[0].is_last);
        if (bus.resp_ready) begin
          if (cur_len < 16) cur[cur_len] = bus.resp_data;
          cur_len++;
          if (exp_q[0].is_last) begin
            in_resp   = 1'b0;
            last_resp = cur;
            last_len  = cur_len;
            cur_len   = 0;
            if (img_q.size() != 0) begin
              check("ctrl_out_at_end", ctrl_out, img_q[0].ctrl);
              check("timeout_count_at_end", timeout_count, img_q[0].tmo);
              void'(img_q.pop_front());
            end
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // resp_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = held low
  int rr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       bus.resp_ready = 1'b1;
      1:       bus.resp_ready = ~bus.resp_ready;
      default: bus.resp_ready = 1'b0;
    endcase
  end

  task automatic send(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                      input int from, input int upto, output int acc);
    int t;
    acc = 0;
    for (int i = from; i < upto; i++) begin
      bus.cmd_data  = (i == 0) ? b0 : (i == 1) ? b1 : b2;
      bus.cmd_valid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!bus.cmd_ready && t < 200) begin @(negedge clk); t++; end
      if (!bus.cmd_ready) check("cmd_ready_wait", 0, 1);
      acc = cyc;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int acc, input int lat_exp);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < TO + 200) begin @(posedge clk); #1; t++; end
    check({nm, "_done"}, exp_q.size(), 0);
    check({nm, "_latency"}, first_valid_cyc - acc, lat_exp);
    exp_q.delete();
    img_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic run_cmd(input string nm, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input int n);
    int acc;
    model_push(b0, b1, b2, n);
    send(b0, b1, b2, 0, n, acc);
    wait_done(nm, acc, (n < 1 + argc(b0)) ? TO + 2 : 2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got %0d expected 0 stuck", 1);
    $fatal(1);
  end

  initial begin
    int acc;
    bus.cmd_valid = 1'b0;
    bus.cmd_data  = 8'h00;
    for (int i = 0; i < NS; i++) status_m[i] = '0;
    for (int i = 0; i < NC; i++) ctrl_m[i] = 8'h00;
    tmo_m = 8'h00;

    #12;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_resp_valid", bus.resp_valid, 0);
    check("rst_resp_last", bus.resp_last, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    check("rst_pulse_out", pulse_out, 0);
    check("rst_timeout_count", timeout_count, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // VERSION
    run_cmd("version", 8'hF0, 8'h00, 8'h00, 1);
    check("version_len", last_len, 4 + CS);
    check("version_b0", last_resp[0], 8'hF0);
    check("version_b1", last_resp[1], 8'h02);
    check("version_b2", last_resp[2], 8'h00);
    check("version_b3", last_resp[3], 8'h00);
`ifdef DEBUG_CMD_CHECKSUM_EN
    check("version_csum", last_resp[4], 8'hF2);
`endif

    // WR_CTRL then RD_CTRL
    run_cmd("wr_ctrl", 8'h02, 8'h03, 8'hA5, 3);
    check("wr_b1", last_resp[1], 8'h03);
    check("wr_b2", last_resp[2], 8'hA5);
    check("ctrl3", ctrl_out[31:24], 8'hA5);
    check("ctrl_others", ctrl_out & ~64'hFF00_0000, 0);
    run_cmd("rd_ctrl", 8'h03, 8'h03, 8'h00, 2);
    check("rd_ctrl_b0", last_resp[0], 8'h03);
    check("rd_ctrl_b1", last_resp[1], 8'hA5);
    run_cmd("wr_ctrl_bad", 8'h02, 8'h10, 8'h77, 3);
    check("wr_bad_b0", last_resp[0], 8'hFE);

    // RD_STATUS snapshot: word changes in the cycle after EXEC
    status_m[2] = 32'hDEADBEEF;
    model_push(8'h01, 8'h02, 8'h00, 2);
    send(8'h01, 8'h02, 8'h00, 0, 2, acc);
    @(posedge clk); #1;
    status_m[2] = 32'h1234_5678;
    wait_done("rd_status", acc, 2);
    check("rd_status_len", last_len, 5 + CS);
    check("rd_status_b1", last_resp[1], 8'hEF);
    check("rd_status_b4", last_resp[4], 8'hDE);

    // Same read with a stalling sink
    status_m[2] = 32'hDEADBEEF;
    rr_mode = 1;
    run_cmd("rd_status_stall", 8'h01, 8'h02, 8'h00, 2);
    rr_mode = 0;
    check("stall_len", last_len, 5 + CS);
    check("stall_b2", last_resp[2], 8'hBE);
    check("stall_b3", last_resp[3], 8'hAD);
    run_cmd("rd_status_bad", 8'h01, 8'h08, 8'h00, 2);

    // Pulses
    pulse_hits = 0;
    run_cmd("pulse5", 8'h04, 8'h05, 8'h00, 2);
    check("pulse5_hits", pulse_hits, 1);
    check("pulse5_value", pulse_last, 8'h20);
    pulse_hits = 0;
    run_cmd("pulse9", 8'h04, 8'h09, 8'h00, 2);
    check("pulse9_b0", last_resp[0], 8'hFE);
    check("pulse9_b1", last_resp[1], 8'h09);
    check("pulse9_hits", pulse_hits, 0);

    // Unknown opcode
    run_cmd("unknown", 8'h7E, 8'h00, 8'h00, 1);
    check("unknown_b0", last_resp[0], 8'hFF);

    // Argument arriving one cycle before the timeout limit is still accepted
    model_push(8'h02, 8'h06, 8'h5A, 3);
    send(8'h02, 8'h06, 8'h5A, 0, 2, acc);
    repeat (TO - 1) @(posedge clk);
    #1;
    send(8'h02, 8'h06, 8'h5A, 2, 3, acc);
    wait_done("late_arg", acc, 2);
    check("late_arg_ctrl6", ctrl_out[55:48], 8'h5A);

    // Full timeout
    run_cmd("timeout", 8'h02, 8'h00, 8'h00, 1);
    check("timeout_b0", last_resp[0], 8'hFD);
    check("timeout_b1", last_resp[1], 8'h02);
    check("timeout_count", timeout_count, 1);
    run_cmd("nop", 8'h00, 8'h00, 8'h00, 1);
    check("nop_len", last_len, 1 + CS);
    check("nop_b0", last_resp[0], 8'h00);
`ifdef DEBUG_CMD_CHECKSUM_EN
    check("nop_csum", last_resp[1], 8'h00);
`endif

    // Reset while a response is stalled
    rr_mode = 2;
    model_push(8'hF0, 8'h00, 8'h00, 1);
    send(8'hF0, 8'h00, 8'h00, 0, 1, acc);
    begin
      int t = 0;
      while (!bus.resp_valid && t < 20) begin @(negedge clk); t++; end
    end
    check("pre_reset_valid", bus.resp_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_resp_valid", bus.resp_valid, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ctrl", ctrl_out, 0);
    check("mid_rst_tmo", timeout_count, 0);
    exp_q.delete();
    img_q.delete();
    for (int i = 0; i < NC; i++) ctrl_m[i] = 8'h00;
    tmo_m = 8'h00;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rr_mode = 0;
    @(posedge clk); #1;
    run_cmd("nop_after_rst", 8'h00, 8'h00, 8'h00, 1);
    check("nop_after_rst_b0", last_resp[0], 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
